// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage, held-request memory read into an IR
// Ports: Clk/Reset, PCout/PCin/PCWrite, mem_req/addr/ack/rdata, redirect, ir_*, fetch_err
module fetch_unit #(
  parameter int PC_INC   = 1,
  parameter int MAX_WAIT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] PCout,
  output logic [15:0] PCin,
  output logic        PCWrite,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic [15:0] ir_out,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD,
    DRAIN
  } state_t;

  localparam logic [15:0] INC  = 16'(PC_INC);
  localparam logic [7:0]  MAXW = 8'(MAX_WAIT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [7:0]  cnt_inc;
  logic [15:0] next_addr;
  logic        xfer;

  assign xfer      = ir_valid & ir_ready;
  assign next_addr = redirect ? redirect_target : PCout;
  assign cnt_inc   = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
  assign mem_req   = !Reset && (state == WAIT || state == DRAIN);

  // Redirect wins over the sequential increment.
  always_comb begin
    PCWrite = 1'b0;
    PCin    = mem_addr + INC;
    if (!Reset) begin
      if (redirect) begin
        PCWrite = 1'b1;
        PCin    = redirect_target;
      end else if (state == WAIT && mem_ack) begin
        PCWrite = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      ir_out    <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= WAIT;
          mem_addr <= next_addr;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            if (redirect) begin
              // Returned word is stale; reissue at the target at once.
              mem_addr <= redirect_target;
            end else begin
              ir_out   <= mem_rdata;
              ir_pc    <= mem_addr;
              ir_valid <= 1'b1;
              state    <= HOLD;
            end
          end else begin
            wait_cnt <= cnt_inc;
            if (cnt_inc == MAXW) fetch_err <= 1'b1;
            // Outstanding read must finish before a new address goes out.
            if (redirect) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            state    <= WAIT;
            mem_addr <= next_addr;
          end else begin
            wait_cnt <= cnt_inc;
            if (cnt_inc == MAXW) fetch_err <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect || xfer) begin
            ir_valid <= 1'b0;
            state    <= WAIT;
            mem_addr <= next_addr;
            wait_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand sequences and random stream check
// Holds the PC register and a variable-latency instruction memory model
module tb_fetch_unit;

  localparam int MAX_WAIT = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] PCout;
  logic [15:0] PCin;
  logic        PCWrite;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_target;
  logic [15:0] ir_out;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        fetch_err;

  logic [15:0] pc;
  logic [15:0] pc_init;
  logic        pc_load;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  assign PCout = pc;

  always @(posedge Clk) begin
    if (pc_load) pc <= pc_init;
    else if (PCWrite) pc <= PCin;
  end

  fetch_unit #(.PC_INC(1), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .PCout(PCout),
    .PCin(PCin),
    .PCWrite(PCWrite),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .ir_out(ir_out),
    .ir_pc(ir_pc),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .fetch_err(fetch_err)
  );

  typedef struct {
    logic        rd;
    logic [15:0] tgt;
    logic        ack;
    logic [15:0] rdata;
    logic        rdy;
    logic        pw;
    logic [15:0] pcin;
    logic        req;
    logic [15:0] addr;
    logic        iv;
    logic [15:0] iout;
    logic [15:0] ipc;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t v(
    input logic rd, input logic [15:0] tgt, input logic ack,
    input logic [15:0] rdata, input logic rdy, input logic pw,
    input logic [15:0] pcin, input logic req, input logic [15:0] addr,
    input logic iv, input logic [15:0] iout, input logic [15:0] ipc);
    vec_t r;
    r.rd = rd; r.tgt = tgt; r.ack = ack; r.rdata = rdata; r.rdy = rdy;
    r.pw = pw; r.pcin = pcin; r.req = req; r.addr = addr;
    r.iv = iv; r.iout = iout; r.ipc = ipc;
    return r;
  endfunction

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [15:0] tgt,
                       input logic ack, input logic [15:0] rdata,
                       input logic rdy);
    @(negedge Clk);
    Reset = 1'b0;
    pc_load = 1'b0;
    redirect = rd;
    redirect_target = tgt;
    mem_ack = ack;
    mem_rdata = rdata;
    ir_ready = rdy;
    #1;
  endtask

  // Leaves Reset high; the next drive releases it.
  task automatic do_reset(input logic [15:0] start);
    @(negedge Clk);
    Reset = 1'b1;
    redirect = 1'b1;
    redirect_target = 16'h0BAD;
    mem_ack = 1'b0;
    ir_ready = 1'b0;
    pc_init = start;
    pc_load = 1'b1;
    #1;
    chk1("rst_gate_req", mem_req, 1'b0);
    chk1("rst_gate_pcw", PCWrite, 1'b0);
    @(negedge Clk);
    #1;
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_pcw", PCWrite, 1'b0);
    chk1("rst_iv", ir_valid, 1'b0);
    chk1("rst_err", fetch_err, 1'b0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_iout", ir_out, 16'h0000);
    chk("rst_ipc", ir_pc, 16'h0000);
  endtask

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] prev_addr, prev_iout, prev_ipc;
    logic        prev_req, prev_ack, prev_hold;
    logic        rd, ack, rdy;
    logic [15:0] tgt, rdata;
    int          lat, ndel;

    Reset = 1'b1;
    redirect = 1'b0;
    redirect_target = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    ir_ready = 1'b0;
    pc_init = 16'h0010;
    pc_load = 1'b1;

    tab.push_back(v(0,0,0,0,0,      0,0,0,16'h0000,0,0,0));
    tab.push_back(v(0,0,0,0,0,      0,0,1,16'h0010,0,0,0));
    tab.push_back(v(0,0,1,16'hA5A5,0, 1,16'h0011,1,16'h0010,0,0,0));
    for (int i = 0; i < 5; i++)
      tab.push_back(v(0,0,0,0,0,    0,0,0,16'h0010,1,16'hA5A5,16'h0010));
    tab.push_back(v(0,0,0,0,1,      0,0,0,16'h0010,1,16'hA5A5,16'h0010));
    tab.push_back(v(0,0,0,0,0,      0,0,1,16'h0011,0,0,0));
    tab.push_back(v(1,16'h0200,0,0,0, 1,16'h0200,1,16'h0011,0,0,0));
    tab.push_back(v(0,0,0,0,0,      0,0,1,16'h0011,0,0,0));
    tab.push_back(v(0,0,1,16'hDEAD,0, 0,0,1,16'h0011,0,0,0));
    tab.push_back(v(0,0,1,16'h0BEE,0, 1,16'h0201,1,16'h0200,0,0,0));
    tab.push_back(v(0,0,0,0,1,      0,0,0,16'h0200,1,16'h0BEE,16'h0200));
    tab.push_back(v(1,16'h0200,1,16'h1234,0, 1,16'h0200,1,16'h0201,0,0,0));
    tab.push_back(v(0,0,0,0,0,      0,0,1,16'h0200,0,0,0));
    tab.push_back(v(0,0,1,16'h5678,0, 1,16'h0201,1,16'h0200,0,0,0));
    tab.push_back(v(0,0,0,0,1,      0,0,0,16'h0200,1,16'h5678,16'h0200));
    tab.push_back(v(1,16'hFFFF,1,16'h0000,0, 1,16'hFFFF,1,16'h0201,0,0,0));
    tab.push_back(v(0,0,1,16'hC0DE,0, 1,16'h0000,1,16'hFFFF,0,0,0));
    tab.push_back(v(0,0,0,0,0,      0,0,0,16'hFFFF,1,16'hC0DE,16'hFFFF));
    tab.push_back(v(1,16'h0300,0,0,1, 1,16'h0300,0,16'hFFFF,1,16'hC0DE,16'hFFFF));
    tab.push_back(v(0,0,0,0,0,      0,0,1,16'h0300,0,0,0));

    do_reset(16'h0010);
    foreach (tab[i]) begin
      drive(tab[i].rd, tab[i].tgt, tab[i].ack, tab[i].rdata, tab[i].rdy);
      chk1($sformatf("v%0d_pcw", i), PCWrite, tab[i].pw);
      if (tab[i].pw) chk($sformatf("v%0d_pcin", i), PCin, tab[i].pcin);
      chk1($sformatf("v%0d_req", i), mem_req, tab[i].req);
      chk($sformatf("v%0d_addr", i), mem_addr, tab[i].addr);
      chk1($sformatf("v%0d_iv", i), ir_valid, tab[i].iv);
      if (tab[i].iv) begin
        chk($sformatf("v%0d_iout", i), ir_out, tab[i].iout);
        chk($sformatf("v%0d_ipc", i), ir_pc, tab[i].ipc);
      end
    end

    // Reset in the middle of a fetch; a late ack lands in IDLE.
    do_reset(16'h0500);
    drive(0, 0, 1, 16'h9999, 0);
    chk1("late_ack_pcw", PCWrite, 1'b0);
    chk1("late_ack_req", mem_req, 1'b0);
    drive(0, 0, 0, 0, 0);
    chk1("after_rst_req", mem_req, 1'b1);
    chk("after_rst_addr", mem_addr, 16'h0500);
    chk1("after_rst_iv", ir_valid, 1'b0);
    drive(0, 0, 1, 16'h4242, 0);
    chk1("after_rst_pcw", PCWrite, 1'b1);
    chk("after_rst_pcin", PCin, 16'h0501);
    drive(0, 0, 0, 0, 1);
    chk1("after_rst_iv2", ir_valid, 1'b1);
    chk("after_rst_iout", ir_out, 16'h4242);
    chk("after_rst_ipc", ir_pc, 16'h0500);

    // Redirect out of IDLE, then a memory timeout.
    do_reset(16'h0600);
    drive(1, 16'h0400, 0, 0, 0);
    chk1("idle_rd_pcw", PCWrite, 1'b1);
    chk("idle_rd_pcin", PCin, 16'h0400);
    for (int i = 1; i <= MAX_WAIT + 3; i++) begin
      drive(0, 0, 0, 0, 0);
      chk1($sformatf("to%0d_req", i), mem_req, 1'b1);
      chk($sformatf("to%0d_addr", i), mem_addr, 16'h0400);
      chk1($sformatf("to%0d_err", i), fetch_err, (i - 1) >= MAX_WAIT);
    end
    drive(0, 0, 1, 16'h7777, 0);
    chk1("to_ack_pcw", PCWrite, 1'b1);
    chk("to_ack_pcin", PCin, 16'h0401);
    drive(0, 0, 0, 0, 1);
    chk1("to_iv", ir_valid, 1'b1);
    chk("to_iout", ir_out, 16'h7777);
    chk("to_ipc", ir_pc, 16'h0400);
    chk1("to_err_sticky", fetch_err, 1'b1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk1("to_err_sticky2", fetch_err, 1'b1);

    // Random traffic against an instruction-stream model.
    do_reset(16'hFFF0);
    exp_pc = 16'hFFF0;
    lat = int'($urandom_range(0, 3));
    ndel = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_hold = 1'b0;
    prev_addr = '0;
    prev_iout = '0;
    prev_ipc = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      ack = 1'b0;
      rdata = 16'($urandom);
      if (mem_req) begin
        if (lat == 0) begin
          ack = 1'b1;
          rdata = word_at(mem_addr);
          lat = int'($urandom_range(0, 3));
        end else begin
          lat--;
        end
      end
      rd = ($urandom_range(0, 11) == 0);
      tgt = 16'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      Reset = 1'b0;
      pc_load = 1'b0;
      redirect = rd;
      redirect_target = tgt;
      mem_ack = ack;
      mem_rdata = rdata;
      ir_ready = rdy;
      #1;
      if (prev_req && mem_req && !prev_ack)
        chk("rnd_addr_hold", mem_addr, prev_addr);
      if (prev_hold) begin
        chk1("rnd_iv_hold", ir_valid, 1'b1);
        chk("rnd_iout_hold", ir_out, prev_iout);
        chk("rnd_ipc_hold", ir_pc, prev_ipc);
      end
      if (ir_valid && ir_ready) begin
        chk("rnd_ipc", ir_pc, exp_pc);
        chk("rnd_iout", ir_out, word_at(ir_pc));
        exp_pc = ir_pc + 16'd1;
        ndel++;
      end
      if (rd) begin
        chk1("rnd_rd_pcw", PCWrite, 1'b1);
        chk("rnd_rd_pcin", PCin, tgt);
        exp_pc = tgt;
      end
      prev_req = mem_req;
      prev_ack = ack;
      prev_addr = mem_addr;
      prev_hold = ir_valid && !rdy && !rd;
      prev_iout = ir_out;
      prev_ipc = ir_pc;
    end
    chk1("rnd_no_err", fetch_err, 1'b0);
    n_cmp++;
    if (ndel < 100) begin
      n_bad++;
      $display("FAIL rnd_deliveries: got %0d expected at least 100", ndel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
